// File: rtl/packed_pixel_unpacker.sv
// Unpacks Y4/Y1 framebuffer words into Y8 pixel beats through a one-word gearbox.
// Each line starts on a word boundary; vsync flushes all pipeline state.
module packed_pixel_unpacker #(
  parameter int unsigned IN_BITS    = 32,
  parameter int unsigned PIXEL_BITS = 4,
  parameter int unsigned PIXEL_RATE = 4,
  parameter int unsigned H_PIXELS   = 1600
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsync,
  input  logic [IN_BITS-1:0]      in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*PIXEL_RATE-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int unsigned BEAT_BITS      = PIXEL_RATE * PIXEL_BITS;
  localparam int unsigned BEATS_PER_WORD = IN_BITS / BEAT_BITS;
  localparam int unsigned BEATS_PER_LINE = H_PIXELS / PIXEL_RATE;
  localparam int unsigned IDX_W  = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam int unsigned LINE_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam int unsigned REP    = 8 / PIXEL_BITS;

  logic [IN_BITS-1:0]      word;
  logic                    word_full;
  logic [IDX_W-1:0]        beat_idx;
  logic [LINE_W-1:0]       line_beat;
  logic                    load;
  logic                    last_of_word;
  logic                    line_end;
  logic                    retire;
  logic [31:0]             shamt;
  logic [IN_BITS-1:0]      shifted;
  logic [BEAT_BITS-1:0]    slice;
  logic [8*PIXEL_RATE-1:0] expanded;

  assign load         = word_full && (!out_valid || out_ready);
  assign last_of_word = (beat_idx == IDX_W'(BEATS_PER_WORD - 1));
  assign line_end     = (line_beat == LINE_W'(BEATS_PER_LINE - 1));
  // A word retires on its final beat or when the line ends early inside it.
  assign retire       = load && (last_of_word || line_end);
  assign in_ready     = rst_n && !vsync && (!word_full || retire);

  // Select the current beat (MSB-first) and replicate each pixel up to 8 bits.
  always_comb begin
    shamt    = (32'(BEATS_PER_WORD) - 32'd1 - 32'(beat_idx)) * 32'(BEAT_BITS);
    shifted  = word >> shamt;
    slice    = shifted[BEAT_BITS-1:0];
    expanded = '0;
    for (int k = 0; k < int'(PIXEL_RATE); k++) begin
      expanded[8*k +: 8] = {REP{slice[PIXEL_BITS*k +: PIXEL_BITS]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || vsync) begin
      word      <= '0;
      word_full <= 1'b0;
      beat_idx  <= '0;
      line_beat <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        word      <= in_data;
        word_full <= 1'b1;
      end else if (retire) begin
        word_full <= 1'b0;
      end

      if (load) begin
        out       <= expanded;
        out_valid <= 1'b1;
        out_last  <= line_end;
        beat_idx  <= retire ? '0 : beat_idx + IDX_W'(1);
        line_beat <= line_end ? '0 : line_beat + LINE_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packed_pixel_unpacker.sv
// Randomized bench for packed_pixel_unpacker: three configurations (Y4 long line,
// Y1 long line, Y4 12-pixel line) checked against a pixel-level reference model.
`timescale 1ns/1ps
module tb_packed_pixel_unpacker;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        out_ready;
  logic [31:0] in_data;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [31:0] out_w     [3];
  logic        out_valid [3];
  logic        out_last  [3];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] tx_q [$];
  beat_t       exp_q [$];
  beat_t       got_q [$];
  int          first_acc;

  always #5 clk = ~clk;

  packed_pixel_unpacker #(.IN_BITS(32), .PIXEL_BITS(4), .PIXEL_RATE(4), .H_PIXELS(1600)) u_y4 (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .in_data(in_data), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out(out_w[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_last(out_last[0]));

  packed_pixel_unpacker #(.IN_BITS(32), .PIXEL_BITS(1), .PIXEL_RATE(4), .H_PIXELS(1600)) u_y1 (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .in_data(in_data), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out(out_w[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_last(out_last[1]));

  packed_pixel_unpacker #(.IN_BITS(32), .PIXEL_BITS(4), .PIXEL_RATE(4), .H_PIXELS(12)) u_short (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .in_data(in_data), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out(out_w[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_last(out_last[2]));

  // Reference: walk pixels of each word left to right, restart line on a fresh word.
  task automatic build_model(input int sel);
    int pb;
    int h;
    int bpw;
    int bpl;
    int lb;
    pb  = (sel == 1) ? 1 : 4;
    h   = (sel == 2) ? 12 : 1600;
    bpw = 32 / (4 * pb);
    bpl = h / 4;
    lb  = 0;
    exp_q.delete();
    foreach (tx_q[w]) begin
      for (int b = 0; b < bpw; b++) begin
        beat_t e;
        e.data = 32'd0;
        for (int k = 0; k < 4; k++) begin
          int pos;
          int p;
          pos = b * 4 + k;
          p = int'((tx_q[w] >> (32 - (pos + 1) * pb)) & ((32'd1 << pb) - 32'd1));
          e.data = (e.data << 8) | 32'((pb == 4) ? p * 17 : p * 255);
        end
        e.last = (lb == bpl - 1);
        e.cyc  = 0;
        exp_q.push_back(e);
        lb = e.last ? 0 : lb + 1;
        if (e.last) break;
      end
    end
  endtask

  task automatic flush();
    @(posedge clk); #1;
    vsync = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b0;
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. vmode: 0 valid whenever data, 1 random.
  task automatic run_stream(input int sel, input int rmode, input int vmode, input int budget);
    int          cyc;
    logic        stall;
    logic [31:0] hold_d;
    logic        hold_l;
    beat_t       g;
    int          n;
    cyc   = 0;
    stall = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    build_model(sel);
    got_q.delete();
    first_acc = -1;
    while ((tx_q.size() > 0 || got_q.size() < exp_q.size()) && cyc < budget) begin
      @(posedge clk); #1;
      in_valid[sel] = (tx_q.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
      in_data = (tx_q.size() > 0) ? tx_q[0] : $urandom;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      if (stall) begin
        n_checks++;
        if (out_valid[sel] !== 1'b1 || out_w[sel] !== hold_d || out_last[sel] !== hold_l) begin
          n_fail++;
          $display("FAIL hold_stable inst%0d cyc%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   sel, cyc, out_valid[sel], out_w[sel], out_last[sel], hold_d, hold_l);
        end
      end
      stall  = out_valid[sel] && !out_ready;
      hold_d = out_w[sel];
      hold_l = out_last[sel];
      if (out_valid[sel] && out_ready) begin
        g.data = out_w[sel];
        g.last = out_last[sel];
        g.cyc  = cyc;
        got_q.push_back(g);
      end
      if (in_valid[sel] && in_ready[sel]) begin
        if (first_acc < 0) first_acc = cyc;
        void'(tx_q.pop_front());
      end
      cyc++;
    end
    in_valid[sel] = 1'b0;
    n_checks++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL timeout inst%0d: got %0d beats after %0d cycles, want %0d", sel, got_q.size(), cyc, exp_q.size());
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL beat_count inst%0d: got %0d, want %0d", sel, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
        n_fail++;
        $display("FAIL beat inst%0d #%0d: got %h last=%b, want %h last=%b",
                 sel, i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vsync = 1'b0;
    out_ready = 1'b1;
    in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b0 || out_w[i] !== 32'd0 || out_last[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset inst%0d: got v=%b rdy=%b out=%h last=%b, want 0 0 0 0",
                   i, out_valid[i], in_ready[i], out_w[i], out_last[i]);
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release inst%0d: got v=%b rdy=%b, want v=0 rdy=1", i, out_valid[i], in_ready[i]);
      end
    end
  endtask

  task automatic test_vsync_flush();
    flush();
    in_data = $urandom;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid[0] = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (out_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL vsync_setup: got out_valid=%b, want 1", out_valid[0]);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vsync = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL vsync_in_ready cyc%0d: got %b, want 0", c, in_ready[0]);
      end
      if (c == 1) begin
        n_checks++;
        if (out_valid[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL vsync_out_valid: got %b, want 0", out_valid[0]);
        end
      end
    end
    @(posedge clk); #1;
    vsync = 1'b0;
    in_valid[0] = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL vsync_stale cyc%0d: got out_valid=%b, want 0", c, out_valid[0]);
      end
    end
  endtask

  task automatic test_y4_order();
    flush();
    tx_q.delete();
    tx_q.push_back(32'h1234_5678);
    run_stream(0, 0, 0, 50);
    n_checks++;
    if (got_q.size() < 2 || got_q[0].data !== 32'h1122_3344 || got_q[1].data !== 32'h5566_7788) begin
      n_fail++;
      $display("FAIL y4_order: got %0d beats first %h, want 11223344 55667788",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
    end
  endtask

  task automatic test_y1_expand();
    logic ok;
    flush();
    tx_q.delete();
    tx_q.push_back(32'hA000_0000);
    run_stream(1, 0, 0, 50);
    ok = (got_q.size() == 8) && (got_q[0].data === 32'hFF00_FF00);
    for (int i = 1; i < got_q.size(); i++) if (got_q[i].data !== 32'd0) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL y1_expand: got %0d beats first %h, want 8 beats FF00FF00 then zeros",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
    end
  endtask

  task automatic test_line_end();
    flush();
    tx_q.delete();
    tx_q.push_back(32'h0123_4567);
    tx_q.push_back(32'h89AB_CDEF);
    tx_q.push_back(32'h1357_9BDF);
    tx_q.push_back(32'h2468_ACE0);
    run_stream(2, 0, 0, 50);
    n_checks++;
    if (got_q.size() != 6 || got_q[2].data !== 32'h8899_AABB || got_q[2].last !== 1'b1 ||
        got_q[3].data !== 32'h1133_5577 || got_q[3].last !== 1'b0 || got_q[5].last !== 1'b1) begin
      n_fail++;
      $display("FAIL line_end: got %0d beats, beat2=%h beat3=%h, want 6 beats 8899AABB(last) 11335577",
               got_q.size(), (got_q.size() > 2) ? got_q[2].data : 32'h0,
               (got_q.size() > 3) ? got_q[3].data : 32'h0);
    end
  endtask

  task automatic test_backpressure();
    flush();
    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back($urandom);
    run_stream(0, 1, 0, 200);
    flush();
    tx_q.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back($urandom);
    run_stream(2, 2, 1, 600);
  endtask

  task automatic test_random_y1();
    flush();
    tx_q.delete();
    for (int i = 0; i < 10; i++) tx_q.push_back($urandom);
    run_stream(1, 2, 1, 600);
  endtask

  task automatic test_streaming();
    flush();
    tx_q.delete();
    for (int i = 0; i < 100; i++) tx_q.push_back($urandom);
    run_stream(0, 0, 0, 400);
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].cyc != first_acc + 2 + i) begin
        n_fail++;
        $display("FAIL stream_timing beat%0d: got cycle %0d, want %0d", i, got_q[i].cyc, first_acc + 2 + i);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    test_reset();
    test_vsync_flush();
    test_y4_order();
    test_y1_expand();
    test_line_end();
    test_backpressure();
    test_random_y1();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
